// File: rtl/lsu_multicyc_pkg.sv
// Shared encodings for the multi-cycle load/store unit: access sizes, FSM states and fault codes.
package lsu_multicyc_pkg;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR      = 3'd3,
      S_WR_WAIT = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   typedef enum logic [1:0] {FLT_NONE = 2'd0, FLT_MISALIGN = 2'd1, FLT_TIMEOUT = 2'd2} fault_e;

   function automatic int size_bytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

endpackage

// File: rtl/lsu_multicyc_lane.sv
// lsu_lane: combinational lane extract/extend for loads and lane placement/merge for stores.
module lsu_lane
   import lsu_multicyc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]           word,
   input  logic [XLEN-1:0]           wdata,
   input  logic [$clog2(XLEN/8)-1:0] off,
   input  logic [1:0]                size,
   input  logic                      uns,
   output logic [XLEN-1:0]           ext,
   output logic [XLEN-1:0]           merged,
   output logic [XLEN-1:0]           placed,
   output logic [XLEN/8-1:0]         lanes
);
   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] bytemask;
   int              nbits;

   always_comb begin
      shifted = word >> {off, 3'b000};
      nbits   = 8 * size_bytes(size);
      if (nbits > XLEN) nbits = XLEN;
      ext = shifted;
      for (int i = 0; i < XLEN; i++) begin
         if (i >= nbits) ext[i] = uns ? 1'b0 : shifted[nbits-1];
      end
      placed = wdata << {off, 3'b000};
      for (int b = 0; b < NB; b++) begin
         lanes[b]         = (b >= int'(off)) && (b < int'(off) + size_bytes(size));
         bytemask[8*b+:8] = {8{lanes[b]}};
      end
      merged = (word & ~bytemask) | (placed & bytemask);
   end

endmodule

// File: rtl/lsu_multicyc.sv
// lsu_multicyc: multi-cycle load/store unit with strobed bus, wait counting and timeout.
// Define LSU_BYTEMASK_EN for byte-strobed single-write stores; otherwise sub-word stores use RMW.
module lsu_multicyc
   import lsu_multicyc_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              st,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   rdata,
   output logic              fault_misalign,
   output logic              fault_timeout,
   output logic [XLEN-1:0]   a,
   output logic [XLEN-1:0]   d,
   output logic              we,
   output logic              rd,
   input  logic [XLEN-1:0]   spo,
`ifdef LSU_BYTEMASK_EN
   output logic [XLEN/8-1:0] be,
`endif
   input  logic              ready
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT + 1) + 1;

   state_e          state;
   fault_e          fault;
   logic [CW-1:0]   cnt;
   logic [1:0]      size_q;
   logic            uns_q;
   logic            rmw_q;
   logic [OW-1:0]   off_q;
   logic [XLEN-1:0] wdata_q;

   logic            idle;
   logic [1:0]      l_size;
   logic            l_uns;
   logic [OW-1:0]   l_off;
   logic [XLEN-1:0] l_wdata, l_word, l_ext, l_merged, l_placed;
   logic [NB-1:0]   l_lanes;
   logic            misalign;
   logic            timed_out;

   // Bus words are byte-reversed relative to the internal little-endian view.
   function automatic logic [XLEN-1:0] bswap(input logic [XLEN-1:0] x);
      logic [XLEN-1:0] r;
      for (int i = 0; i < NB; i++) r[8*i+:8] = x[XLEN-8-8*i+:8];
      return r;
   endfunction

   always_comb begin
      idle      = (state == S_IDLE);
      l_size    = idle ? funct3[1:0]     : size_q;
      l_uns     = idle ? funct3[2]       : uns_q;
      l_off     = idle ? addr[OW-1:0]    : off_q;
      l_wdata   = idle ? wdata           : wdata_q;
      l_word    = bswap(spo);
      misalign  = ((funct3[1:0] == SZ_D) && (XLEN == 32)) ||
                  ((addr[OW-1:0] & OW'(size_bytes(funct3[1:0]) - 1)) != '0);
      timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
   end

   lsu_lane #(.XLEN(XLEN)) u_lane (
      .word   (l_word),
      .wdata  (l_wdata),
      .off    (l_off),
      .size   (l_size),
      .uns    (l_uns),
      .ext    (l_ext),
      .merged (l_merged),
      .placed (l_placed),
      .lanes  (l_lanes)
   );

   assign fault_misalign = (fault == FLT_MISALIGN);
   assign fault_timeout  = (fault == FLT_TIMEOUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         fault   <= FLT_NONE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd      <= 1'b0;
         we      <= 1'b0;
         a       <= '0;
         d       <= '0;
         rdata   <= '0;
         cnt     <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         rmw_q   <= 1'b0;
         off_q   <= '0;
         wdata_q <= '0;
`ifdef LSU_BYTEMASK_EN
         be      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (req) begin
               busy <= 1'b1;
               if (misalign) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  fault <= FLT_MISALIGN;
               end else begin
                  size_q  <= funct3[1:0];
                  uns_q   <= funct3[2];
                  off_q   <= addr[OW-1:0];
                  wdata_q <= wdata;
                  a       <= {addr[XLEN-1:OW], {OW{1'b0}}};
                  cnt     <= '0;
`ifdef LSU_BYTEMASK_EN
                  rmw_q   <= 1'b0;
                  if (st) begin
                     state <= S_WR;
                     we    <= 1'b1;
                     d     <= bswap(l_placed);
                     be    <= l_lanes;
                  end else begin
                     state <= S_RD;
                     rd    <= 1'b1;
                     be    <= '1;
                  end
`else
                  // All lanes touched means a full-width store: no read needed.
                  rmw_q   <= st && !(&l_lanes);
                  if (st && (&l_lanes)) begin
                     state <= S_WR;
                     we    <= 1'b1;
                     d     <= bswap(l_placed);
                  end else begin
                     state <= S_RD;
                     rd    <= 1'b1;
                  end
`endif
               end
            end
            S_RD, S_RD_WAIT: begin
               rd <= 1'b0;
               if (ready) begin
                  if (rmw_q) begin
                     state <= S_WR;
                     we    <= 1'b1;
                     d     <= bswap(l_merged);
                     cnt   <= '0;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     rdata <= l_ext;
                  end
               end else if (timed_out) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  fault <= FLT_TIMEOUT;
               end else begin
                  state <= S_RD_WAIT;
                  cnt   <= cnt + CW'(1);
               end
            end
            S_WR, S_WR_WAIT: begin
               we <= 1'b0;
               if (ready) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (timed_out) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  fault <= FLT_TIMEOUT;
               end else begin
                  state <= S_WR_WAIT;
                  cnt   <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               fault <= FLT_NONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_multicyc.sv
// Randomized self-checking bench for lsu_multicyc against a byte-level memory reference model.
module tb_lsu_multicyc;
   localparam int XLEN = 32;
   localparam int TO   = 4;
`ifdef LSU_BYTEMASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, req, st, busy, done, fault_misalign, fault_timeout, we, rd, ready;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rdata, a, d, spo;
`ifdef LSU_BYTEMASK_EN
   logic [3:0]  be;
`endif

   always #5 clk = ~clk;

   lsu_multicyc #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .st(st), .funct3(funct3), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .fault_misalign(fault_misalign),
      .fault_timeout(fault_timeout), .a(a), .d(d), .we(we), .rd(rd), .spo(spo),
`ifdef LSU_BYTEMASK_EN
      .be(be),
`endif
      .ready(ready)
   );

   logic [31:0] mem     [0:63];
   logic [31:0] exp_mem [0:63];
   logic [31:0] exp_rdata;
   int          n_checks = 0;
   int          n_pass   = 0;

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   always_comb spo = (a[31:8] == 24'h1) ? bswap(mem[a[7:2]]) : 32'h0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Bus responder: wait counts come from wq, stall withholds ready entirely.
   int          wq[$];
   bit          stall = 1'b0;
   bit          pending, pend_we;
   int          wait_left;
   int          strobes = 0;
   logic [31:0] pend_a, pend_d;
   logic [3:0]  last_be = 4'h0;

   initial begin
      ready   = 1'b0;
      pending = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ready   = 1'b0;
            pending = 1'b0;
         end else begin
            if (ready) begin
               ready = 1'b0;
               if (pending && pend_we && pend_a[31:8] == 24'h1) begin
`ifdef LSU_BYTEMASK_EN
                  for (int k = 0; k < 4; k++)
                     if (last_be[k]) mem[pend_a[7:2]][8*k+:8] = bswap(pend_d) >> (8*k);
`else
                  mem[pend_a[7:2]] = bswap(pend_d);
`endif
               end
               pending = 1'b0;
            end
            if (rd || we) begin
               strobes++;
               pending   = 1'b1;
               pend_we   = we;
               pend_a    = a;
               pend_d    = d;
`ifdef LSU_BYTEMASK_EN
               last_be   = be;
`endif
               wait_left = stall ? -1 : ((wq.size() > 0) ? wq.pop_front() : 0);
            end else if (pending && wait_left > 0) begin
               wait_left--;
            end
            if (pending && wait_left == 0) ready = 1'b1;
         end
      end
   end

   function automatic logic [31:0] model_load(input logic [31:0] ad, input logic [2:0] f3);
      int          n;
      longint      v;
      logic [31:0] w;
      n = 1 << f3[1:0];
      v = 0;
      w = exp_mem[(ad >> 2) & 63];
      for (int k = 0; k < n; k++) v += longint'((w >> (8 * ((ad + k) % 4))) & 32'hFF) << (8 * k);
      if (!f3[2] && v >= (64'd1 << (8 * n - 1))) v -= (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   task automatic model_store(input logic [31:0] ad, input logic [2:0] f3, input logic [31:0] wd);
      int n;
      int idx;
      n   = 1 << f3[1:0];
      idx = (ad >> 2) & 63;
      for (int k = 0; k < n; k++) exp_mem[idx][8*((ad+k)%4)+:8] = wd[8*k+:8];
   endtask

   task automatic txn(input bit s, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                      input int w0, input int w1, input bit tmo, input bit req_at_done, input string tag);
      int          n, lat, got, s0, nstr, idx;
      bit          mis, rmw;
      logic [31:0] er;
      n   = 1 << f3[1:0];
      mis = (f3[1:0] == 2'd3) || ((ad % n) != 0);
      rmw = s && !mis && (n < 4) && !MASK;
      idx = (ad >> 2) & 63;
      if (tmo) begin
         stall = 1'b1; lat = 1 + TO; nstr = 1;
      end else if (mis) begin
         lat = 1; nstr = 0;
      end else begin
         wq.push_back(w0);
         if (rmw) begin wq.push_back(w1); lat = 3 + w0 + w1; nstr = 2; end
         else begin lat = 2 + w0; nstr = 1; end
      end
      er = (!s && !mis && !tmo) ? model_load(ad, f3) : exp_rdata;
      s0 = strobes;
      req = 1'b1; st = s; funct3 = f3; addr = ad; wdata = wd;
      @(negedge clk);
      req = 1'b0;
      if (!mis) check({tag, "_addr"}, a, ad & 32'hFFFF_FFFC);
      got = 0;
      for (int c = 1; c <= 30; c++) begin
         if (c > 1) @(negedge clk);
         if (done) begin got = c; break; end
      end
      check({tag, "_latency"}, got, lat);
      check({tag, "_misalign"}, fault_misalign, mis);
      check({tag, "_timeout"}, fault_timeout, tmo);
      check({tag, "_busy_at_done"}, busy, 1);
      if (!s && !mis && !tmo) begin
         check({tag, "_rdata"}, rdata, er);
         exp_rdata = er;
      end
      if (s && !mis && !tmo) model_store(ad, f3, wd);
      if (req_at_done) req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_strobes"}, strobes - s0, nstr);
      if (s && !mis && !tmo) check({tag, "_memword"}, mem[idx], exp_mem[idx]);
      stall = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b0; st = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
      exp_rdata = 32'h0;
      for (int i = 0; i < 64; i++) begin
         mem[i]     = $urandom;
         exp_mem[i] = mem[i];
      end
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_rd_we", {rd, we}, 0);
      check("reset_faults", {fault_misalign, fault_timeout}, 0);
      check("reset_rdata", rdata, 0);
      check("reset_a", a, 0);
`ifdef LSU_BYTEMASK_EN
      check("reset_be", be, 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      mem[0] = 32'h1234_5678; exp_mem[0] = mem[0];
      txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 1'b0, 1'b1, "lw_basic");
      check("lw_basic_value", rdata, 32'h1234_5678);

      mem[0] = 32'h80AA_BBCC; exp_mem[0] = mem[0];
      txn(1'b0, 3'b000, 32'h103, 32'h0, 1, 0, 1'b0, 1'b0, "lb_sign");
      check("lb_sign_value", rdata, 32'hFFFF_FF80);
      txn(1'b0, 3'b100, 32'h103, 32'h0, 2, 0, 1'b0, 1'b0, "lbu_zero");
      check("lbu_zero_value", rdata, 32'h0000_0080);

      mem[0] = 32'h1122_3344; exp_mem[0] = mem[0];
      txn(1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 1, 1, 1'b0, 1'b0, "sh_merge");
      check("sh_merge_word", mem[0], 32'hBEEF_3344);
`ifdef LSU_BYTEMASK_EN
      check("sh_merge_be", last_be, 4'b1100);
`endif

      txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 1'b0, 1'b0, "lw_misalign");
      txn(1'b0, 3'b011, 32'h108, 32'h0, 0, 0, 1'b0, 1'b0, "ld_xlen32");
      txn(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 1'b1, 1'b0, "lw_timeout");
      txn(1'b1, 3'b010, 32'h10C, 32'hCAFE_F00D, 2, 0, 1'b0, 1'b0, "sw_full");

      // Reset asserted while a strobe is on the bus must drop it at once.
      for (int t = 0; t < 2; t++) begin
         bit seen;
         wq.push_back(0); wq.push_back(0);
         req = 1'b1; st = (t == 1); funct3 = (t == 1) ? 3'b000 : 3'b010;
         addr = (t == 1) ? 32'h105 : 32'h110; wdata = 32'h5A;
         @(negedge clk);
         req = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 10; c++) begin
            if ((t == 0 && rd) || (t == 1 && we)) begin seen = 1'b1; break; end
            @(negedge clk);
         end
         check(t == 0 ? "rst_strobe_seen_rd" : "rst_strobe_seen_we", seen, 1);
         #1 rst = 1'b1;
         #1;
         check("rst_mid_rd_we", {rd, we}, 0);
         check("rst_mid_busy_done", {busy, done}, 0);
         check("rst_mid_a", a, 0);
         check("rst_mid_rdata", rdata, 0);
         @(negedge clk);
         rst = 1'b0;
         wq.delete();
         exp_rdata = 32'h0;
         check("rst_mid_mem_untouched", mem[1], exp_mem[1]);
         @(negedge clk);
      end

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  f3;
         logic [31:0] ad;
         int          n;
         f3[1:0] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         f3[2]   = 1'($urandom_range(0, 1));
         n       = 1 << f3[1:0];
         ad      = 32'h100 + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) ad = ad & ~(32'(n) - 32'd1);
         txn(1'($urandom_range(0, 1)), f3, ad, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
             1'b0, 1'($urandom_range(0, 1)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
